// File: rtl/row_load_ctrl.sv
// Row load sequencer: takes a row stream over valid/ready, writes rows into the
// matrix row buffer, ends the matrix (full or early on in_last), waits for the
// buffer's set flag and then offers the finished matrix downstream.
module row_load_ctrl #(
  parameter int DATA_SIZE   = 16,
  parameter int COLUMN_SIZE = 8,
  parameter int ROW_SIZE    = 8,
  parameter int SET_TIMEOUT = 16
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              in_last,
  input  logic [DATA_SIZE*ROW_SIZE-1:0]     in_dats,
  output logic                              buf_enable,
  output logic                              buf_dend,
  output logic [DATA_SIZE*ROW_SIZE-1:0]     buf_dats,
  input  logic                              buf_dset,
  output logic                              mat_valid,
  input  logic                              mat_ready,
  output logic [$clog2(COLUMN_SIZE):0]      mat_rows,
  output logic                              busy,
  output logic                              err_timeout,
  input  logic                              err_clr
);

  localparam int CW = $clog2(COLUMN_SIZE) + 1;
  localparam int TW = $clog2(SET_TIMEOUT) + 1;
  localparam int DW = DATA_SIZE * ROW_SIZE;

  typedef enum logic [1:0] {
    LOAD     = 2'd0,
    FLUSH    = 2'd1,
    WAIT_SET = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   rowCnt_q, rowCnt_d;
  logic [TW-1:0]   tmoCnt_q, tmoCnt_d;
  logic            bufEnable_q, bufEnable_d;
  logic            bufDend_q, bufDend_d;
  logic [DW-1:0]   bufDats_q, bufDats_d;
  logic            matValid_q, matValid_d;
  logic [CW-1:0]   matRows_q, matRows_d;
  logic            errTimeout_q, errTimeout_d;
  logic [CW-1:0]   rowInc;

  assign rowInc = rowCnt_q + CW'(1);

  // Next-state logic: one matrix in flight, buffer pulses default low each cycle
  always_comb begin
    state_d      = state_q;
    rowCnt_d     = rowCnt_q;
    tmoCnt_d     = tmoCnt_q;
    bufEnable_d  = 1'b0;
    bufDend_d    = 1'b0;
    bufDats_d    = bufDats_q;
    matValid_d   = matValid_q;
    matRows_d    = matRows_q;
    errTimeout_d = err_clr ? 1'b0 : errTimeout_q;

    case (state_q)
      LOAD: begin
        if (in_valid) begin
          bufEnable_d = 1'b1;
          bufDats_d   = in_dats;
          rowCnt_d    = rowInc;
          if (rowInc == CW'(COLUMN_SIZE) || in_last) begin
            matRows_d = rowInc;
            state_d   = FLUSH;
          end
        end
      end
      FLUSH: begin
        bufEnable_d = 1'b1;
        bufDend_d   = 1'b1;
        tmoCnt_d    = '0;
        state_d     = WAIT_SET;
      end
      WAIT_SET: begin
        if (tmoCnt_q != '0 && buf_dset) begin
          matValid_d = 1'b1;
          state_d    = HOLD;
        end else if (tmoCnt_q == TW'(SET_TIMEOUT - 1)) begin
          errTimeout_d = 1'b1;
          rowCnt_d     = '0;
          matRows_d    = '0;
          state_d      = LOAD;
        end else begin
          tmoCnt_d = tmoCnt_q + TW'(1);
        end
      end
      HOLD: begin
        if (mat_ready) begin
          matValid_d = 1'b0;
          rowCnt_d   = '0;
          state_d    = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= LOAD;
      rowCnt_q     <= '0;
      tmoCnt_q     <= '0;
      bufEnable_q  <= 1'b0;
      bufDend_q    <= 1'b0;
      bufDats_q    <= '0;
      matValid_q   <= 1'b0;
      matRows_q    <= '0;
      errTimeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rowCnt_q     <= rowCnt_d;
      tmoCnt_q     <= tmoCnt_d;
      bufEnable_q  <= bufEnable_d;
      bufDend_q    <= bufDend_d;
      bufDats_q    <= bufDats_d;
      matValid_q   <= matValid_d;
      matRows_q    <= matRows_d;
      errTimeout_q <= errTimeout_d;
    end
  end

  assign in_ready    = (state_q == LOAD);
  assign busy        = (state_q != LOAD) || (rowCnt_q != '0);
  assign buf_enable  = bufEnable_q;
  assign buf_dend    = bufDend_q;
  assign buf_dats    = bufDats_q;
  assign mat_valid   = matValid_q;
  assign mat_rows    = matRows_q;
  assign err_timeout = errTimeout_q;

endmodule
